// File: rtl/rf_writeback_arbiter.sv
// Sole register-file write port: core writebacks win unless WAW/starved, else in-order accelerator FIFO drains.
// Latency: core 1 cycle, accelerator >=1 cycle after enqueue; acc_ready drops when the FIFO is full (no pass-through).
module rf_writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_wr_en,
  input  logic [4:0]                   core_rd,
  input  logic [31:0]                  core_data,
  output logic                         core_stall,
  input  logic                         acc_valid,
  output logic                         acc_ready,
  input  logic [4:0]                   acc_rd,
  input  logic [31:0]                  acc_data,
  input  logic [4:0]                   q_rs1,
  input  logic [4:0]                   q_rs2,
  output logic                         hazard,
  output logic                         write_reg,
  output logic [4:0]                   rd,
  output logic [31:0]                  data_in,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]       q_rd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [SW-1:0]    starve_cnt;
  logic [DEPTH-1:0] slot_vld;
  logic             core_active;
  logic             core_win;
  logic             waw;
  logic             starved;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // A slot is live when its distance from head (mod DEPTH) is below the occupancy.
  always_comb begin
    slot_vld = '0;
    waw      = 1'b0;
    hazard   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_vld[i] = CW'(PW'(i) - head) < fifo_count;
      if (slot_vld[i]) begin
        if (q_rd[i] == core_rd) waw = 1'b1;
        if ((q_rs1 != 5'd0 && q_rd[i] == q_rs1) || (q_rs2 != 5'd0 && q_rd[i] == q_rs2))
          hazard = 1'b1;
      end
    end
  end

  assign fifo_empty  = (fifo_count == '0);
  assign acc_ready   = reset && (fifo_count < CW'(DEPTH));
  assign core_active = core_wr_en && (core_rd != 5'd0);
  assign starved     = (starve_cnt == SW'(STARVE_MAX));
  assign core_stall  = core_active && (waw || starved);
  assign core_win    = core_active && !core_stall;
  assign pop         = !core_win && !fifo_empty;
  // Writes to x0 complete the handshake but never occupy a slot.
  assign push        = acc_valid && acc_ready && (acc_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= acc_rd;
      q_data[tail] <= acc_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      starve_cnt <= '0;
      write_reg  <= 1'b0;
      rd         <= 5'd0;
      data_in    <= 32'd0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);

      if (pop || fifo_empty)
        starve_cnt <= '0;
      else if (core_win && !starved)
        starve_cnt <= starve_cnt + 1'b1;

      write_reg <= core_win || pop;
      if (core_win) begin
        rd      <= core_rd;
        data_in <= core_data;
      end else if (pop) begin
        rd      <= q_rd[head];
        data_in <= q_data[head];
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed stimulus pushes expected register writes into a queue; a negedge monitor pops and compares them.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_wr_en;
  logic [4:0]  core_rd;
  logic [31:0] core_data;
  logic        core_stall;
  logic        acc_valid;
  logic        acc_ready;
  logic [4:0]  acc_rd;
  logic [31:0] acc_data;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        hazard;
  logic        write_reg;
  logic [4:0]  rd;
  logic [31:0] data_in;
  logic [2:0]  fifo_count;

  rf_writeback_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .core_wr_en(core_wr_en), .core_rd(core_rd), .core_data(core_data), .core_stall(core_stall),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_rd(acc_rd), .acc_data(acc_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .hazard(hazard),
    .write_reg(write_reg), .rd(rd), .data_in(data_in), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] regs [32];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (write_reg === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h want no write", rd, data_in);
      end else begin
        mon_e = exp_q.pop_front();
        if (rd !== mon_e.rd || data_in !== mon_e.dat) begin
          bad++;
          $display("FAIL wb_order: got rd=%0d data=%0h want rd=%0d data=%0h",
                   rd, data_in, mon_e.rd, mon_e.dat);
        end
      end
      regs[rd] = data_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic core(input logic en, input logic [4:0] r, input logic [31:0] d);
    core_wr_en = en;
    core_rd    = r;
    core_data  = d;
  endtask

  task automatic acc(input logic v, input logic [4:0] r, input logic [31:0] d);
    acc_valid = v;
    acc_rd    = r;
    acc_data  = d;
  endtask

  initial begin
    core(1'b0, 5'd0, 32'd0);
    acc(1'b1, 5'd9, 32'h900d);
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;

    // Reset held with acc_valid asserted: nothing may be accepted or written.
    tick();
    tick();
    chk("rst_write_reg", 32'(write_reg), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_data_in", data_in, 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_acc_ready", 32'(acc_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_acc_ready", 32'(acc_ready), 32'd1);
    expect_wr(5'd9, 32'h900d);
    tick();
    acc(1'b0, 5'd0, 32'd0);
    #1;
    chk("first_enq_count", 32'(fifo_count), 32'd1);
    tick();
    chk("first_pop_count", 32'(fifo_count), 32'd0);

    // Plain core write with an empty FIFO, then output holds while idle.
    core(1'b1, 5'd5, 32'hA5);
    #1;
    chk("core_no_stall", 32'(core_stall), 32'd0);
    expect_wr(5'd5, 32'hA5);
    tick();
    core(1'b0, 5'd0, 32'd0);
    tick();
    chk("idle_write_reg", 32'(write_reg), 32'd0);
    chk("idle_rd_hold", 32'(rd), 32'd5);
    chk("idle_data_hold", data_in, 32'hA5);

    // Fill the FIFO while the core keeps winning, then drain in order.
    for (int i = 0; i < 4; i++) begin
      core(1'b1, 5'(20 + i), 32'h200 + 32'(i));
      acc(1'b1, 5'(1 + i), 32'h100 + 32'(i));
      expect_wr(5'(20 + i), 32'h200 + 32'(i));
      tick();
    end
    core(1'b0, 5'd0, 32'd0);
    acc(1'b1, 5'd6, 32'h666);
    #1;
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_acc_ready", 32'(acc_ready), 32'd0);
    for (int i = 0; i < 4; i++) expect_wr(5'(1 + i), 32'h100 + 32'(i));
    tick();
    acc(1'b0, 5'd0, 32'd0);
    #1;
    chk("full_no_passthru_count", 32'(fifo_count), 32'd3);
    tick();
    tick();
    tick();
    chk("drain_count", 32'(fifo_count), 32'd0);

    // WAW: queued rd=7 must reach the register file before the core's rd=7.
    core(1'b1, 5'd10, 32'h10a);
    acc(1'b1, 5'd7, 32'h7acc);
    expect_wr(5'd10, 32'h10a);
    tick();
    acc(1'b0, 5'd0, 32'd0);
    core(1'b1, 5'd7, 32'h77);
    #1;
    chk("waw_stall", 32'(core_stall), 32'd1);
    expect_wr(5'd7, 32'h7acc);
    tick();
    chk("waw_release", 32'(core_stall), 32'd0);
    expect_wr(5'd7, 32'h77);
    tick();
    core(1'b0, 5'd0, 32'd0);
    tick();
    chk("waw_final_reg7", regs[7], 32'h77);

    // Starvation: after 8 core wins over a nonempty FIFO the core is held one cycle.
    core(1'b1, 5'd13, 32'h1300);
    acc(1'b1, 5'd11, 32'hb0b);
    expect_wr(5'd13, 32'h1300);
    tick();
    core(1'b1, 5'd14, 32'h1400);
    acc(1'b1, 5'd12, 32'hc0c);
    expect_wr(5'd14, 32'h1400);
    tick();
    acc(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      core(1'b1, 5'(15 + i), 32'h1500 + 32'(i));
      #1;
      chk("starve_pre", 32'(core_stall), 32'd0);
      expect_wr(5'(15 + i), 32'h1500 + 32'(i));
      tick();
    end
    core(1'b1, 5'd22, 32'h222);
    #1;
    chk("starve_stall", 32'(core_stall), 32'd1);
    expect_wr(5'd11, 32'hb0b);
    expect_wr(5'd22, 32'h222);
    tick();
    chk("starve_release", 32'(core_stall), 32'd0);
    tick();
    core(1'b0, 5'd0, 32'd0);
    expect_wr(5'd12, 32'hc0c);
    tick();
    tick();

    // RAW hazard queries against queued destinations; rd=0 results are dropped.
    core(1'b1, 5'd25, 32'h2500);
    acc(1'b1, 5'd3, 32'h333);
    expect_wr(5'd25, 32'h2500);
    tick();
    core(1'b1, 5'd26, 32'h2600);
    acc(1'b1, 5'd0, 32'hdead);
    q_rs1 = 5'd3;
    #1;
    chk("hazard_rs1", 32'(hazard), 32'd1);
    q_rs1 = 5'd4;
    #1;
    chk("hazard_rs1_miss", 32'(hazard), 32'd0);
    expect_wr(5'd26, 32'h2600);
    tick();
    acc(1'b0, 5'd0, 32'd0);
    #1;
    chk("rd0_discard_count", 32'(fifo_count), 32'd1);
    core(1'b1, 5'd27, 32'h2700);
    q_rs1 = 5'd0;
    q_rs2 = 5'd3;
    #1;
    chk("hazard_rs2", 32'(hazard), 32'd1);
    q_rs2 = 5'd0;
    #1;
    chk("hazard_zero_query", 32'(hazard), 32'd0);
    expect_wr(5'd27, 32'h2700);
    tick();
    core(1'b0, 5'd0, 32'd0);
    q_rs2 = 5'd3;
    expect_wr(5'd3, 32'h333);
    tick();
    chk("hazard_after_pop", 32'(hazard), 32'd0);
    q_rs2 = 5'd0;

    // Reset mid-operation discards the queued entry and issues no write afterwards.
    core(1'b1, 5'd28, 32'h2800);
    acc(1'b1, 5'd8, 32'h888);
    expect_wr(5'd28, 32'h2800);
    tick();
    core(1'b0, 5'd0, 32'd0);
    acc(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_write_reg", 32'(write_reg), 32'd0);
    chk("midrst_rd", 32'(rd), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("midrst_after_count", 32'(fifo_count), 32'd0);

    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
